// File: rtl/j_chunk_fetcher.sv
// Streams the J matrix from memory as NUM_J_CHUNKS word-sized chunks through a
// small credit-limited FIFO, with abort (drain outstanding reads) and in-order responses.
module j_chunk_fetcher #(
    parameter int MEM_BANDWIDTH   = 4096,
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int ADDR_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 2,
    parameter int NUM_J_CHUNKS    = VECTOR_SIZE * VECTOR_SIZE * J_ELEMENT_WIDTH / MEM_BANDWIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr,
    input  logic                              mem_rsp_valid,
    input  logic [MEM_BANDWIDTH-1:0]          mem_rsp_data,
    output logic                              chunk_valid,
    input  logic                              chunk_ready,
    output logic [MEM_BANDWIDTH-1:0]          chunk_data,
    output logic [$clog2(NUM_J_CHUNKS)-1:0]   chunk_idx,
    output logic                              chunk_last
);

    localparam int IDX_W = $clog2(NUM_J_CHUNKS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [IDX_W-1:0]        req_cnt_q, req_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [MEM_BANDWIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic active;
    logic credit_ok;
    logic req_fire;
    logic rsp_take;
    logic push;
    logic pop;

    // Abort wins over everything in its cycle, so it also masks the request and the pop.
    assign active        = (state_q == FETCH) || (state_q == DRAIN);
    assign credit_ok     = (out_cnt_q + count_q) < CNT_W'(FIFO_DEPTH);
    assign mem_req_valid = (state_q == FETCH) && credit_ok && !abort;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_take      = mem_rsp_valid && (out_cnt_q != '0) && (state_q != IDLE);
    assign push          = rsp_take && active && !abort;
    assign chunk_valid   = (count_q != '0);
    assign pop           = chunk_valid && chunk_ready && active && !abort;

    assign busy          = (state_q != IDLE);
    assign mem_req_addr  = base_q + ADDR_WIDTH'(req_cnt_q);
    assign chunk_data    = fifo_mem[rd_ptr_q];
    assign chunk_idx     = idx_q;
    assign chunk_last    = (idx_q == IDX_W'(NUM_J_CHUNKS - 1));
    assign done          = pop && chunk_last;

    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q + IDX_W'(req_fire);
        idx_d     = idx_q + IDX_W'(pop);
        out_cnt_d = out_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);

        case (state_q)
            IDLE: begin
                out_cnt_d = '0;
                if (start) begin
                    state_d   = FETCH;
                    base_d    = base_addr;
                    req_cnt_d = '0;
                    idx_d     = '0;
                end
            end
            FETCH, DRAIN: begin
                if (abort) begin
                    state_d  = FLUSH;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else if (done) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (req_fire && req_cnt_q == IDX_W'(NUM_J_CHUNKS - 1)) begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if (out_cnt_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            idx_q     <= '0;
            out_cnt_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            idx_q     <= idx_d;
            out_cnt_q <= out_cnt_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // NOTE: the data array is left unreset; entries are only read once the occupancy count says they were written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rsp_data;
    end

endmodule

// File: tb/tb_j_chunk_fetcher.sv
// Scoreboard bench for j_chunk_fetcher: a 3-cycle memory model, request and chunk
// monitors popping expected queues, and directed nominal/backpressure/stall/abort/reset runs.
module tb_j_chunk_fetcher;

    localparam int MB  = 64;
    localparam int AW  = 16;
    localparam int NUM = 64;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid = 1'b0;
    logic [MB-1:0] mem_rsp_data = '0;
    logic          chunk_valid;
    logic          chunk_ready = 1'b0;
    logic [MB-1:0] chunk_data;
    logic [5:0]    chunk_idx;
    logic          chunk_last;

    j_chunk_fetcher #(
        .MEM_BANDWIDTH(MB), .VECTOR_SIZE(16), .J_ELEMENT_WIDTH(16),
        .ADDR_WIDTH(AW), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .busy(busy), .done(done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .chunk_data(chunk_data),
        .chunk_idx(chunk_idx), .chunk_last(chunk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MB-1:0] data;
        int            idx;
        logic          last;
    } chunk_t;

    chunk_t        exp_chunk[$];
    logic [AW-1:0] exp_addr[$];
    int checks = 0, errors = 0;
    int fires = 0, rsps = 0, pops = 0, done_cnt = 0;

    function automatic logic [MB-1:0] word_of(input logic [AW-1:0] a);
        return {a, ~a, a ^ 16'hA5A5, a + 16'h1234};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Memory model: fixed latency, in order, drops everything in flight on reset.
    logic          pv [LAT] = '{default: 1'b0};
    logic [AW-1:0] pa [LAT] = '{default: '0};
    logic          fire_seen = 1'b0;
    logic [AW-1:0] fire_addr = '0;

    always @(negedge clk) begin
        fire_seen = rst_n && mem_req_valid && mem_req_ready;
        fire_addr = mem_req_addr;
        if (rst_n && mem_rsp_valid) rsps++;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0] = fire_seen;
            pa[0] = fire_addr;
        end
        mem_rsp_valid = pv[LAT-1];
        mem_rsp_data  = word_of(pa[LAT-1]);
    end

    // Request monitor
    always @(negedge clk) begin
        if (rst_n && mem_req_valid && mem_req_ready) begin
            fires++;
            if (exp_addr.size() == 0) check("req_unexpected", 1, 0);
            else check("req_addr", mem_req_addr, exp_addr.pop_front());
        end
    end

    // Chunk monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (chunk_valid && chunk_ready && !abort) begin
                pops++;
                if (exp_chunk.size() == 0) begin
                    check("chunk_unexpected", 1, 0);
                end else begin
                    chunk_t e;
                    e = exp_chunk.pop_front();
                    check("chunk_data", chunk_data, e.data);
                    check("chunk_idx", 64'(chunk_idx), 64'(e.idx));
                    check("chunk_last", chunk_last, e.last);
                    check("done_flag", done, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [AW-1:0] b);
        for (int i = 0; i < NUM; i++) begin
            chunk_t e;
            e.data = word_of(b + AW'(i));
            e.idx  = i;
            e.last = (i == NUM - 1);
            exp_chunk.push_back(e);
            exp_addr.push_back(b + AW'(i));
        end
        base_addr = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 4000) begin
            step();
            n++;
        end
        check(tag, 64'(done_cnt - d0), 1);
        check("busy_after_done", busy, 0);
        check("sb_drained", 64'(exp_chunk.size() + exp_addr.size()), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_chunk_valid", chunk_valid, 0);
        check("rst_done", done, 0);
        check("rst_chunk_last", chunk_last, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_chunk_idx", 64'(chunk_idx), 0);
    endtask

    initial begin
        int pb, fb, d0, r0, f0, n;
        logic [MB-1:0] hold;
        logic [AW-1:0] a0;

        repeat (2) step();
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Nominal run with a stray start in the middle of the fetch
        mem_req_ready = 1'b1;
        chunk_ready   = 1'b1;
        pb = pops;
        launch(16'h0100);
        n = 0;
        while (pops - pb < 20 && n < 1000) begin step(); n++; end
        base_addr = 16'h0BAD;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("nominal_done");
        check("nominal_pops", 64'(pops - pb), 64);

        // Downstream backpressure, then a request-side stall
        chunk_ready = 1'b0;
        pb = pops;
        fb = fires;
        launch(16'h0200);
        n = 0;
        @(negedge clk);
        while (!chunk_valid && n < 100) begin @(negedge clk); n++; end
        check("bp_first_valid", chunk_valid, 1);
        hold = chunk_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_no_req", mem_req_valid, 0);
            check("bp_data_stable", chunk_data, hold);
        end
        step();
        check("bp_occupancy", 64'((fires - fb) - (pops - pb)), 2);
        chunk_ready   = 1'b1;
        mem_req_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_req_valid && n < 100) begin @(negedge clk); n++; end
        check("stall_valid_seen", mem_req_valid, 1);
        a0 = mem_req_addr;
        f0 = fires;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", mem_req_valid, 1);
            check("stall_addr", mem_req_addr, a0);
        end
        step();
        check("stall_no_fire", 64'(fires - f0), 0);
        mem_req_ready = 1'b1;
        wait_done("bp_done");

        // Abort with two reads in flight
        pb = pops;
        d0 = done_cnt;
        launch(16'h0300);
        n = 0;
        while (!((pops - pb) >= 10 && (fires - rsps) == 2 && !mem_rsp_valid) && n < 1000) begin
            step();
            n++;
        end
        check("abort_window", 64'(fires - rsps), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        r0 = rsps;
        exp_chunk.delete();
        exp_addr.delete();
        check("abort_chunk_valid", chunk_valid, 0);
        check("abort_busy", busy, 1);
        check("abort_no_req", mem_req_valid, 0);
        n = 0;
        while (busy && n < 50) begin
            check("flush_no_chunk", chunk_valid, 0);
            step();
            n++;
        end
        check("flush_idle", busy, 0);
        check("flush_discarded", 64'(rsps - r0), 2);
        check("abort_no_done", 64'(done_cnt - d0), 0);
        check("idle_empty", chunk_valid, 0);

        // Reset in the middle of a fetch, then a clean restart
        pb = pops;
        launch(16'h0400);
        n = 0;
        while (pops - pb < 30 && n < 1000) begin step(); n++; end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs();
        exp_chunk.delete();
        exp_addr.delete();
        rsps = fires;
        step();
        pb = pops;
        launch(16'h0400);
        wait_done("restart_done");
        check("restart_pops", 64'(pops - pb), 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
